// File: rtl/dkong_rom_arb.sv
// Shares one byte-wide external ROM port between main CPU, sound CPU, wave ROM and download writes.
// Optional DKONG_ROM_ARB_RR_EN: alternate sound/wave priority instead of fixed sound-first.
module dkong_rom_arb #(
  parameter int                MEM_AW   = 20,
  parameter logic [MEM_AW-1:0] SND_BASE = MEM_AW'(20'h10000),
  parameter logic [MEM_AW-1:0] WAV_BASE = MEM_AW'(20'h80000)
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESETn,
  input  logic              I_MAIN_REQ,
  input  logic [15:0]       I_MAIN_A,
  output logic              O_MAIN_ACK,
  output logic [7:0]        O_MAIN_DO,
  input  logic              I_SND_REQ,
  input  logic [11:0]       I_SND_A,
  output logic              O_SND_ACK,
  output logic [7:0]        O_SND_DO,
  input  logic              I_WAV_REQ,
  input  logic [18:0]       I_WAV_A,
  output logic              O_WAV_ACK,
  output logic [7:0]        O_WAV_DO,
  input  logic              DL_WR,
  input  logic [15:0]       DL_ADDR,
  input  logic [7:0]        DL_DATA,
  output logic              O_DL_OVF,
  output logic [MEM_AW-1:0] O_MEM_A,
  output logic              O_MEM_RD,
  output logic              O_MEM_WR,
  output logic [7:0]        O_MEM_DOUT,
  input  logic [7:0]        I_MEM_DIN,
  input  logic              I_MEM_READY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int         NRD    = 3;
  localparam logic [1:0] P_MAIN = 2'd0;
  localparam logic [1:0] P_SND  = 2'd1;
  localparam logic [1:0] P_WAV  = 2'd2;
  localparam logic [1:0] P_DL   = 2'd3;

  state_t            state_reg;
  logic [1:0]        port_reg;
  logic [MEM_AW-1:0] mem_a_reg;
  logic              mem_rd_reg;
  logic              mem_wr_reg;
  logic [7:0]        mem_dout_reg;

  logic              dl_full_reg;
  logic [15:0]       dl_addr_reg;
  logic [7:0]        dl_data_reg;
  logic              dl_ovf_reg;

  logic              hb_valid_reg;
  logic [15:0]       hb_addr_reg;
  logic [7:0]        hb_data_reg;

  logic [NRD-1:0]    req_vec;
  logic [NRD-1:0]    pend_vec;
  logic [NRD-1:0]    ack_vec;
  logic [NRD-1:0]    done_vec;
  logic [NRD-1:0]    hit_vec;
  logic [MEM_AW-1:0] map_addr [NRD];
  logic [MEM_AW-1:0] addr_vec [NRD];
  logic [7:0]        do_vec   [NRD];

  logic              mem_done;
  logic              dl_done;
  logic              dl_accept;
  logic              main_hit;
  logic [15:0]       hb_addr_next;
  logic              snd_first;
  logic              grant;
  logic [1:0]        gport;
  logic [MEM_AW-1:0] gaddr;

  assign mem_done  = (state_reg == WAIT) && I_MEM_READY;
  assign dl_done   = mem_done && (port_reg == P_DL);
  assign dl_accept = DL_WR && !dl_full_reg;

  // A write landing on the buffered address in the same cycle must not be answered from stale data
  assign main_hit = I_MAIN_REQ && !pend_vec[0] && hb_valid_reg && (I_MAIN_A == hb_addr_reg) &&
                    !(dl_accept && (DL_ADDR == hb_addr_reg));

  assign req_vec = {I_WAV_REQ, I_SND_REQ, I_MAIN_REQ && !main_hit};
  assign hit_vec = {2'b00, main_hit};

  assign map_addr[0] = MEM_AW'(I_MAIN_A);
  assign map_addr[1] = SND_BASE + MEM_AW'(I_SND_A);
  assign map_addr[2] = WAV_BASE + MEM_AW'(I_WAV_A);

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic              pend_reg;
      logic              ack_reg;
      logic [MEM_AW-1:0] addr_reg;
      logic [7:0]        do_reg;

      assign done_vec[gi] = mem_done && (port_reg == 2'(gi));
      assign pend_vec[gi] = pend_reg;
      assign ack_vec[gi]  = ack_reg;
      assign addr_vec[gi] = addr_reg;
      assign do_vec[gi]   = do_reg;

      // Pending clears with the memory response, so a REQ in the DONE cycle is latched normally
      always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
          pend_reg <= 1'b0;
          ack_reg  <= 1'b0;
          addr_reg <= '0;
          do_reg   <= '0;
        end else begin
          ack_reg <= done_vec[gi] || hit_vec[gi];
          if (done_vec[gi])
            do_reg <= I_MEM_DIN;
          else if (hit_vec[gi])
            do_reg <= hb_data_reg;
          if (req_vec[gi] && !pend_reg) begin
            pend_reg <= 1'b1;
            addr_reg <= map_addr[gi];
          end else if (done_vec[gi]) begin
            pend_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

`ifdef DKONG_ROM_ARB_RR_EN
  logic last_snd_reg;

  assign snd_first = !last_snd_reg;

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn)
      last_snd_reg <= 1'b0;
    else if (state_reg == IDLE && grant && gport == P_SND)
      last_snd_reg <= 1'b1;
    else if (state_reg == IDLE && grant && gport == P_WAV)
      last_snd_reg <= 1'b0;
  end
`else
  assign snd_first = 1'b1;
`endif

  always_comb begin
    grant = 1'b0;
    gport = P_DL;
    gaddr = '0;
    if (dl_full_reg) begin
      grant = 1'b1;
      gport = P_DL;
      gaddr = MEM_AW'(dl_addr_reg);
    end else if (pend_vec[0]) begin
      grant = 1'b1;
      gport = P_MAIN;
      gaddr = addr_vec[0];
    end else if (pend_vec[1] && (!pend_vec[2] || snd_first)) begin
      grant = 1'b1;
      gport = P_SND;
      gaddr = addr_vec[1];
    end else if (pend_vec[2]) begin
      grant = 1'b1;
      gport = P_WAV;
      gaddr = addr_vec[2];
    end
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_reg    <= IDLE;
      port_reg     <= P_MAIN;
      mem_a_reg    <= '0;
      mem_rd_reg   <= 1'b0;
      mem_wr_reg   <= 1'b0;
      mem_dout_reg <= '0;
    end else begin
      mem_rd_reg <= 1'b0;
      mem_wr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg <= ISSUE;
            port_reg  <= gport;
            mem_a_reg <= gaddr;
            if (gport == P_DL) begin
              mem_wr_reg   <= 1'b1;
              mem_dout_reg <= dl_data_reg;
            end else begin
              mem_rd_reg <= 1'b1;
            end
          end
        end
        ISSUE: state_reg <= WAIT;
        WAIT: begin
          if (I_MEM_READY)
            state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      dl_full_reg <= 1'b0;
      dl_addr_reg <= '0;
      dl_data_reg <= '0;
      dl_ovf_reg  <= 1'b0;
    end else begin
      if (dl_done)
        dl_full_reg <= 1'b0;
      if (DL_WR) begin
        if (dl_full_reg) begin
          dl_ovf_reg <= 1'b1;
        end else begin
          dl_full_reg <= 1'b1;
          dl_addr_reg <= DL_ADDR;
          dl_data_reg <= DL_DATA;
        end
      end
    end
  end

  assign hb_addr_next = done_vec[0] ? addr_vec[0][15:0] : hb_addr_reg;

  // Invalidation comes last so it overrides a fill landing in the same cycle
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      hb_valid_reg <= 1'b0;
      hb_addr_reg  <= '0;
      hb_data_reg  <= '0;
    end else begin
      if (done_vec[0]) begin
        hb_valid_reg <= 1'b1;
        hb_addr_reg  <= addr_vec[0][15:0];
        hb_data_reg  <= I_MEM_DIN;
      end
      if (dl_accept && DL_ADDR == hb_addr_next)
        hb_valid_reg <= 1'b0;
      if (dl_done && dl_addr_reg == hb_addr_reg)
        hb_valid_reg <= 1'b0;
    end
  end

  assign O_MAIN_ACK = ack_vec[0];
  assign O_SND_ACK  = ack_vec[1];
  assign O_WAV_ACK  = ack_vec[2];
  assign O_MAIN_DO  = do_vec[0];
  assign O_SND_DO   = do_vec[1];
  assign O_WAV_DO   = do_vec[2];
  assign O_DL_OVF   = dl_ovf_reg;
  assign O_MEM_A    = mem_a_reg;
  assign O_MEM_RD   = mem_rd_reg;
  assign O_MEM_WR   = mem_wr_reg;
  assign O_MEM_DOUT = mem_dout_reg;

endmodule
